// File: rtl/out_buffer.sv
// out_buffer: result-side stage of the editing accelerator.
// Packs 8-bit PE results into 32-bit words, buffers them in a FIFO and
// streams them out as AXI4-Stream (S2MM) with tlast on the final frame word.
// Ports:
//   clk, rstn                 clock, asynchronous active-low reset
//   i_start, i_frame_bytes    frame start pulse and frame byte length
//   i_res_data/valid,
//   o_res_ready               result byte input handshake
//   m_axis_*                  AXI4-Stream master (tdata/tstrb/tlast/tvalid/tready)
//   o_busy                    not idle
//   o_done                    one-cycle pulse after the tlast word handshakes
module out_buffer #(
  parameter int unsigned FIFO_DEPTH = 1024,
  parameter int unsigned LEN_W      = 17
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             i_start,
  input  logic [LEN_W-1:0] i_frame_bytes,
  input  logic [7:0]       i_res_data,
  input  logic             i_res_valid,
  output logic             o_res_ready,
  output logic [31:0]      m_axis_tdata,
  output logic [3:0]       m_axis_tstrb,
  output logic             m_axis_tlast,
  output logic             m_axis_tvalid,
  input  logic             m_axis_tready,
  output logic             o_busy,
  output logic             o_done
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned EW = 37;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [LEN_W-1:0] len_q, cnt_q;
  logic [31:0]      pack_q;
  logic [1:0]       idx_q;
  logic [AW:0]      wr_ptr_q, rd_ptr_q;
  logic [EW-1:0]    mem [FIFO_DEPTH];
  logic [31:0]      tdata_q;
  logic [3:0]       tstrb_q;
  logic             tlast_q, tvalid_q;

  logic             res_ready_c, busy_c, done_c;
  logic             fifo_full_c, fifo_empty_c;
  logic             accept_c, last_byte_c, push_c, pop_c, out_hs_c;
  logic [31:0]      word_c;
  logic [3:0]       strb_c;
  logic [EW-1:0]    rd_entry_c;

  // FIFO status: extra pointer bit separates full from empty
  assign fifo_empty_c = (wr_ptr_q == rd_ptr_q);
  assign fifo_full_c  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                        (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  // Byte packing: new byte goes into lane idx, higher lanes stay zero
  assign accept_c    = i_res_valid && res_ready_c;
  assign last_byte_c = ((cnt_q + LEN_W'(1)) == len_q);
  assign push_c      = accept_c && ((idx_q == 2'd3) || last_byte_c);
  assign word_c      = pack_q | (32'(i_res_data) << {idx_q, 3'b000});

  always_comb begin
    strb_c = 4'h1;
    case (idx_q)
      2'd0:    strb_c = 4'h1;
      2'd1:    strb_c = 4'h3;
      2'd2:    strb_c = 4'h7;
      default: strb_c = 4'hF;
    endcase
  end

  // Output register refills when empty or when its word leaves this cycle
  assign out_hs_c   = tvalid_q && m_axis_tready;
  assign pop_c      = !fifo_empty_c && (!tvalid_q || m_axis_tready);
  assign rd_entry_c = mem[rd_ptr_q[AW-1:0]];

  // State register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (i_start) state_d = (i_frame_bytes == '0) ? S_DONE : S_RUN;
      S_RUN:   if (accept_c && last_byte_c) state_d = S_DRAIN;
      S_DRAIN: if (out_hs_c && tlast_q) state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    res_ready_c = 1'b0;
    busy_c      = (state_q != S_IDLE);
    done_c      = (state_q == S_DONE);
    if (state_q == S_RUN) res_ready_c = !fifo_full_c && (cnt_q < len_q);
  end

  // Frame length, byte counter and pack register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      len_q  <= '0;
      cnt_q  <= '0;
      pack_q <= '0;
      idx_q  <= '0;
    end else if ((state_q == S_IDLE) && i_start) begin
      len_q  <= i_frame_bytes;
      cnt_q  <= '0;
      pack_q <= '0;
      idx_q  <= '0;
    end else if (accept_c) begin
      cnt_q <= cnt_q + LEN_W'(1);
      if (push_c) begin
        pack_q <= '0;
        idx_q  <= '0;
      end else begin
        pack_q <= word_c;
        idx_q  <= idx_q + 2'd1;
      end
    end
  end

  // FIFO storage, no reset needed: pointers define validity
  always_ff @(posedge clk) begin
    if (push_c) mem[wr_ptr_q[AW-1:0]] <= {last_byte_c, strb_c, word_c};
  end

  // FIFO pointers and AXIS output register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      tdata_q  <= '0;
      tstrb_q  <= '0;
      tlast_q  <= 1'b0;
      tvalid_q <= 1'b0;
    end else begin
      if (push_c) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
      if (pop_c) begin
        rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
        tlast_q  <= rd_entry_c[36];
        tstrb_q  <= rd_entry_c[35:32];
        tdata_q  <= rd_entry_c[31:0];
        tvalid_q <= 1'b1;
      end else if (out_hs_c) begin
        tvalid_q <= 1'b0;
      end
    end
  end

  assign o_res_ready   = res_ready_c;
  assign o_busy        = busy_c;
  assign o_done        = done_c;
  assign m_axis_tdata  = tdata_q;
  assign m_axis_tstrb  = tstrb_q;
  assign m_axis_tlast  = tlast_q;
  assign m_axis_tvalid = tvalid_q;

endmodule

// File: tb/tb_out_buffer.sv
// tb_out_buffer: scoreboard bench for out_buffer.
// Stimulus pushes the expected word list of each frame into a queue; a
// negedge monitor pops and compares every AXIS handshake.
module tb_out_buffer;

  localparam int unsigned LEN_W = 17;
  localparam int unsigned DEPTH = 1024;

  logic             clk = 1'b0;
  logic             rstn = 1'b0;
  logic             i_start = 1'b0;
  logic [LEN_W-1:0] i_frame_bytes = '0;
  logic [7:0]       i_res_data = '0;
  logic             i_res_valid = 1'b0;
  logic             o_res_ready;
  logic [31:0]      m_axis_tdata;
  logic [3:0]       m_axis_tstrb;
  logic             m_axis_tlast;
  logic             m_axis_tvalid;
  logic             m_axis_tready = 1'b0;
  logic             o_busy;
  logic             o_done;

  out_buffer #(.FIFO_DEPTH(DEPTH), .LEN_W(LEN_W)) dut (
    .clk(clk), .rstn(rstn), .i_start(i_start), .i_frame_bytes(i_frame_bytes),
    .i_res_data(i_res_data), .i_res_valid(i_res_valid), .o_res_ready(o_res_ready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tstrb(m_axis_tstrb), .m_axis_tlast(m_axis_tlast),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .o_busy(o_busy), .o_done(o_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] d;
    logic [3:0]  s;
    logic        l;
  } exp_t;
  typedef logic [7:0] bq_t[$];

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_checks = 0, n_fail = 0;
  int   cyc = 0;
  int   rdy_mode = 1;  // 0: tready high, 1: low, 2: random
  int   done_cnt = 0, hs_cnt = 0, tlast_cnt = 0;
  int   last_hs_cyc = 0, last_tlast_cyc = 0;
  int   first_rise_cyc = -1, acc3_cyc = -1, bytes_acc = 0;
  bit   tlast_pending = 0, abort = 0;
  bit   stall_prev = 0, prev_done = 0, prev_valid = 0;
  logic [36:0] stall_word = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // tready driver
  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       m_axis_tready = 1'b1;
      1:       m_axis_tready = 1'b0;
      default: m_axis_tready = 1'($urandom_range(0, 1));
    endcase
  end

  // Monitor: scoreboard pop, stall stability, done pulse timing/width
  always @(negedge clk) begin
    if (!rstn) begin
      stall_prev = 0;
      prev_done  = 0;
      prev_valid = 0;
    end else begin
      if (stall_prev) begin
        check("stall_valid", 64'(m_axis_tvalid), 64'd1);
        check("stall_word", 64'({m_axis_tlast, m_axis_tstrb, m_axis_tdata}), 64'(stall_word));
      end
      if (prev_done) check("done_width", 64'(o_done), 64'd0);
      if (m_axis_tvalid && !prev_valid && first_rise_cyc < 0) first_rise_cyc = cyc;
      if (m_axis_tvalid && m_axis_tready) begin
        hs_cnt++;
        last_hs_cyc = cyc;
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_word: got %0h expected none", m_axis_tdata);
        end else begin
          mon_e = exp_q.pop_front();
          check("tdata", 64'(m_axis_tdata), 64'(mon_e.d));
          check("tstrb", 64'(m_axis_tstrb), 64'(mon_e.s));
          check("tlast", 64'(m_axis_tlast), 64'(mon_e.l));
          if (mon_e.l) begin
            tlast_cnt++;
            last_tlast_cyc = cyc;
            tlast_pending  = 1;
          end
        end
      end
      if (o_done) begin
        done_cnt++;
        if (tlast_pending) begin
          check("done_timing", 64'(cyc), 64'(last_tlast_cyc + 1));
          tlast_pending = 0;
        end
      end
      stall_prev = m_axis_tvalid && !m_axis_tready;
      stall_word = {m_axis_tlast, m_axis_tstrb, m_axis_tdata};
      prev_done  = o_done;
      prev_valid = m_axis_tvalid;
    end
  end

  // Issue one frame; expected words come from grouping bytes in fours
  task automatic send_frame(input int n, input bq_t b, input bit rnd_valid);
    int k = 0;
    int t = 0;
    int budget = n * 20 + 200;
    for (int w = 0; w * 4 < n; w++) begin
      exp_t x;
      int   m;
      m   = (n - 4 * w >= 4) ? 4 : n - 4 * w;
      x.d = '0;
      for (int j = 0; j < m; j++) x.d[8*j +: 8] = b[4*w + j];
      x.s = 4'((1 << m) - 1);
      x.l = (4 * w + m == n);
      exp_q.push_back(x);
    end
    bytes_acc = 0;
    @(posedge clk); #1;
    i_start = 1'b1;
    i_frame_bytes = LEN_W'(n);
    @(posedge clk); #1;
    i_start = 1'b0;
    while (k < n && t < budget && !abort) begin
      i_res_valid = rnd_valid ? 1'($urandom_range(0, 1)) : 1'b1;
      i_res_data  = b[k];
      @(negedge clk);
      if (rstn && i_res_valid && o_res_ready) begin
        if (k == 3) acc3_cyc = cyc;
        k++;
        bytes_acc = k;
      end
      @(posedge clk); #1;
      t++;
    end
    i_res_valid = 1'b0;
    if (k < n && !abort) begin
      n_checks++;
      n_fail++;
      $display("FAIL send_timeout: accepted %0d required %0d", k, n);
    end
  endtask

  task automatic wait_done(input int d0, input int budget);
    int t = 0;
    while (done_cnt == d0 && t < budget) begin
      @(posedge clk);
      t++;
    end
    check("done_seen", 64'(done_cnt - d0), 64'd1);
    check("queue_empty", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic rand_bytes(input int n, output bq_t b);
    b = {};
    for (int i = 0; i < n; i++) b.push_back(8'($urandom));
  endtask

  initial begin
    bq_t b;
    int  d0, h0, t0, r0;

    // Reset state
    #2;
    check("rst_tvalid", 64'(m_axis_tvalid), 64'd0);
    check("rst_tdata", 64'(m_axis_tdata), 64'd0);
    check("rst_tstrb", 64'(m_axis_tstrb), 64'd0);
    check("rst_tlast", 64'(m_axis_tlast), 64'd0);
    check("rst_ready", 64'(o_res_ready), 64'd0);
    check("rst_busy", 64'(o_busy), 64'd0);
    check("rst_done", 64'(o_done), 64'd0);
    repeat (3) @(negedge clk);
    rstn = 1'b1;

    // Length 8, incrementing bytes, tready high
    rdy_mode = 0;
    repeat (2) @(posedge clk);
    b = {};
    for (int i = 1; i <= 8; i++) b.push_back(8'(i));
    first_rise_cyc = -1;
    d0 = done_cnt;
    send_frame(8, b, 0);
    wait_done(d0, 100);
    check("latency", 64'(first_rise_cyc - acc3_cyc), 64'd2);

    // Length 6, partial final word
    b = {};
    for (int i = 0; i < 6; i++) b.push_back(8'(8'hA0 + i));
    d0 = done_cnt;
    send_frame(6, b, 0);
    wait_done(d0, 100);

    // Length 4096 with tready held low, then release
    rdy_mode = 1;
    rand_bytes(4096, b);
    d0 = done_cnt;
    r0 = 0;
    h0 = 0;
    fork
      send_frame(4096, b, 0);
      begin
        repeat (4400) @(negedge clk);
        check("stall_accepted", 64'(bytes_acc), 64'd4096);
        check("stall_ready", 64'(o_res_ready), 64'd0);
        check("stall_busy", 64'(o_busy), 64'd1);
        check("stall_tvalid", 64'(m_axis_tvalid), 64'd1);
        h0 = hs_cnt;
        rdy_mode = 0;
        r0 = cyc + 1;
      end
    join
    wait_done(d0, 2000);
    check("burst_words", 64'(hs_cnt - h0), 64'(DEPTH));
    check("burst_no_gaps", 64'(last_hs_cyc - r0), 64'(DEPTH - 1));

    // Length 4104 with tready low: FIFO plus output register cap acceptance
    rdy_mode = 1;
    rand_bytes(4104, b);
    d0 = done_cnt;
    fork
      send_frame(4104, b, 0);
      begin
        repeat (4600) @(negedge clk);
        check("full_accepted", 64'(bytes_acc), 64'd4100);
        check("full_ready", 64'(o_res_ready), 64'd0);
        rdy_mode = 0;
      end
    join
    wait_done(d0, 2000);

    // Length 0: done pulse, no stream traffic
    d0 = done_cnt;
    h0 = hs_cnt;
    @(posedge clk); #1;
    i_start = 1'b1;
    i_frame_bytes = '0;
    @(posedge clk); #1;
    i_start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("len0_no_tvalid", 64'(m_axis_tvalid), 64'd0);
    end
    check("len0_done_once", 64'(done_cnt - d0), 64'd1);
    check("len0_idle", 64'(o_busy), 64'd0);

    // Random valid and tready, length 1001
    rdy_mode = 2;
    rand_bytes(1001, b);
    d0 = done_cnt;
    t0 = tlast_cnt;
    send_frame(1001, b, 1);
    wait_done(d0, 5000);
    check("rand_single_tlast", 64'(tlast_cnt - t0), 64'd1);

    // Reset mid-frame, then a fresh 4-byte frame
    rdy_mode = 1;
    rand_bytes(100, b);
    fork
      send_frame(100, b, 0);
      begin
        repeat (40) @(posedge clk);
        #3;
        rstn  = 1'b0;
        abort = 1;
        #1;
        check("midrst_tvalid", 64'(m_axis_tvalid), 64'd0);
        check("midrst_tdata", 64'(m_axis_tdata), 64'd0);
        check("midrst_ready", 64'(o_res_ready), 64'd0);
        check("midrst_busy", 64'(o_busy), 64'd0);
        exp_q.delete();
        tlast_pending = 0;
      end
    join
    repeat (2) @(negedge clk);
    rstn  = 1'b1;
    abort = 0;
    rdy_mode = 0;
    b = {8'h11, 8'h22, 8'h33, 8'h44};
    d0 = done_cnt;
    h0 = hs_cnt;
    t0 = tlast_cnt;
    send_frame(4, b, 0);
    wait_done(d0, 100);
    check("post_rst_words", 64'(hs_cnt - h0), 64'd1);
    check("post_rst_tlast", 64'(tlast_cnt - t0), 64'd1);

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/out_buffer.md
Name: out_buffer

Overview:
- Result-side stage of the editing accelerator; consumes 8-bit convolution results from the PE array fed by in_buffer.
- Packs result bytes into 32-bit words and buffers them in a block-RAM FIFO.
- Streams the words to the AXI DMA S2MM channel as AXI4-Stream, with tlast on the final word of each frame.
- Frame length in bytes is latched per frame at start.

Parameters:
- FIFO_DEPTH, 1024, number of 32-bit words in the output FIFO (power of two).
- LEN_W, 17, width of the frame byte-length field and the byte counter.

Ports:
- clk  input  1  system clock.
- rstn  input  1  reset; asynchronous and active-low, single clock domain.
- i_start  input  1  one-cycle pulse; latches i_frame_bytes and begins a frame; honoured only in IDLE.
- i_frame_bytes  input  LEN_W  number of result bytes in the frame.
- i_res_data  input  8  result byte from the PE array.
- i_res_valid  input  1  i_res_data is valid.
- o_res_ready  output  1  out_buffer accepts a byte this cycle.
- m_axis_tdata  output  32  packed word; first byte of each group of four in [7:0].
- m_axis_tstrb  output  4  byte qualifiers; 4'hF except on a partial final word.
- m_axis_tlast  output  1  final word of the frame.
- m_axis_tvalid  output  1  word valid.
- m_axis_tready  input  1  downstream ready.
- o_busy  output  1  high in any state other than IDLE.
- o_done  output  1  one-cycle pulse after the tlast word completes its handshake.

Behaviour:
- Reset (asynchronous): state IDLE; byte counter, pack register, lane index and FIFO pointers cleared; all outputs 0.
- State IDLE:
  - On i_start with i_frame_bytes != 0: latch the length, go to RUN.
  - On i_start with i_frame_bytes == 0: go to DONE; no AXIS traffic.
- State RUN:
  - o_res_ready = 1 when FIFO not full and bytes accepted < length.
  - Byte accept = i_res_valid && o_res_ready.
  - Each accepted byte is written to lane[idx] of the pack register; idx increments and wraps 3->0.
  - A word is pushed to the FIFO when lane 3 is written, or when the last byte of the frame is written.
  - Pushed word carries tlast = (last byte of frame) and tstrb = lanes written, e.g. 1 byte -> 4'h1, 3 bytes -> 4'h7. Unused lanes are zero.
  - After the last byte is accepted, go to DRAIN.
- State DRAIN: o_res_ready = 0. When the tlast word handshakes (tvalid && tready), go to DONE.
- State DONE: o_done = 1 for exactly one cycle, then go to IDLE.
- FIFO and output:
  - FIFO entry format: {tlast, tstrb, data} = 37 bits.
  - The output register is loaded whenever it is empty or its word is handshaking and the FIFO is non-empty.
  - Once tvalid is high, tdata/tstrb/tlast are held stable until tready is seen.
- Latency: with the FIFO and output register empty, m_axis_tvalid rises exactly 2 cycles after the accept of the completing byte.
- Throughput: 1 byte/cycle in; 1 word/cycle out under continuous tready.
- Full boundary:
  - FIFO full blocks a push; o_res_ready is deasserted in the same cycle.
  - No byte is ever lost or duplicated.
  - A simultaneous push and pop at full is not allowed; ready stays low while full.
- Empty boundary: no pop when the FIFO is empty; tvalid deasserts after the last word handshakes.
- Wrap-around: FIFO pointers carry one extra bit to distinguish full from empty.
- i_start outside IDLE is ignored.
- i_res_valid outside RUN is ignored and no bytes are accepted.
- Reset mid-frame: everything is cleared immediately; a partially streamed frame is dropped; tvalid drops asynchronously.

Test Plan:
- Length 8, bytes 0x01..0x08, tready=1 -> words 0x04030201 then 0x08070605 (tlast); tstrb 4'hF both; o_done pulses 1 cycle after the second handshake.
- Length 6, bytes 0xA0..0xA5 -> second word 0x0000A5A4, tstrb 4'h3, tlast=1.
- Length 4096, tready held low -> exactly FIFO_DEPTH words buffered, then o_res_ready=0; release tready -> all 1024 words delivered in order with no gaps; data stable while stalled.
- Length 0 start -> o_done 2 cycles later (DONE, then IDLE); m_axis_tvalid never asserts.
- Random i_res_valid and tready, length 1001 -> byte-exact match to a scoreboard; final word tstrb 4'h1, single tlast.
- rstn low mid-frame, then length 4 -> outputs 0 immediately; new frame yields one word with tlast and no stale data.
